// File: rtl/adsr_env_mc_if.sv
// adsr_env_mc_if
// Bundles every non-clock signal of the multi-channel ADSR envelope
// generator: note strobes, shared envelope configuration and the
// registered per-service result stream.
//
// Signals:
//   gate_on / gate_off   per-channel note-on / note-off strobes
//   attack_rate          level increment per attack step
//   decay_rate           level decrement per decay step
//   sustain_level        sustain target level
//   release_rate         level decrement per release step
//   retrig_mode          0: note-on restarts at 0, 1: legato resume
//   out_valid            out_* carry a fresh service result
//   out_ch               channel just serviced
//   out_phase            phase of that channel (IDLE..RELEASE = 0..4)
//   out_level            level of that channel
//   active               bit c set while channel c is not IDLE
//
// Modports: master drives strobes/configuration and observes results,
// slave is the envelope generator side.
interface adsr_env_mc_if #(
    parameter int CHANNELS = 4,
    parameter int LEVEL_W  = 16,
    parameter int RATE_W   = 16
);
    localparam int CH_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0] gate_on;
    logic [CHANNELS-1:0] gate_off;
    logic [RATE_W-1:0]   attack_rate;
    logic [RATE_W-1:0]   decay_rate;
    logic [LEVEL_W-1:0]  sustain_level;
    logic [RATE_W-1:0]   release_rate;
    logic                retrig_mode;
    logic                out_valid;
    logic [CH_W-1:0]     out_ch;
    logic [2:0]          out_phase;
    logic [LEVEL_W-1:0]  out_level;
    logic [CHANNELS-1:0] active;

    modport master (
        output gate_on, gate_off, attack_rate, decay_rate,
               sustain_level, release_rate, retrig_mode,
        input  out_valid, out_ch, out_phase, out_level, active
    );

    modport slave (
        input  gate_on, gate_off, attack_rate, decay_rate,
               sustain_level, release_rate, retrig_mode,
        output out_valid, out_ch, out_phase, out_level, active
    );
endinterface

// File: rtl/adsr_env_mc.sv
// adsr_env_mc
// Time-multiplexed ADSR envelope generator. CHANNELS independent
// envelopes share one update datapath; a round-robin pointer services one
// channel per clock and the result of each service is registered onto the
// out_* stream one cycle later.
//
// Ports:
//   clk   single rising-edge clock
//   rst   synchronous active-low reset
//   bus   adsr_env_mc_if.slave: strobes, configuration, result stream
module adsr_env_mc #(
    parameter int CHANNELS = 4,
    parameter int LEVEL_W  = 16,
    parameter int RATE_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    adsr_env_mc_if.slave      bus
);
    localparam int CH_W = $clog2(CHANNELS);
    localparam int W1   = LEVEL_W + 1;
    localparam logic [LEVEL_W-1:0] MAX = '1;

    typedef enum logic [2:0] {
        P_IDLE    = 3'd0,
        P_ATTACK  = 3'd1,
        P_DECAY   = 3'd2,
        P_SUSTAIN = 3'd3,
        P_RELEASE = 3'd4
    } phase_t;

    phase_t              phase_q [CHANNELS];
    logic [LEVEL_W-1:0]  level_q [CHANNELS];
    logic [CHANNELS-1:0] pend_on_q;
    logic [CHANNELS-1:0] pend_off_q;
    logic [CH_W-1:0]     ch;

    logic                out_valid_q;
    logic [CH_W-1:0]     out_ch_q;
    phase_t              out_phase_q;
    logic [LEVEL_W-1:0]  out_level_q;
    logic [CHANNELS-1:0] active_q;

    phase_t              cur_phase;
    logic [LEVEL_W-1:0]  cur_level;
    logic [W1-1:0]       att_sum;
    logic [W1-1:0]       dec_diff;
    logic [W1-1:0]       rel_diff;
    phase_t              svc_phase;
    logic [LEVEL_W-1:0]  svc_level;

    logic [CHANNELS-1:0] pend_on_d;
    logic [CHANNELS-1:0] pend_off_d;
    logic [CHANNELS-1:0] active_d;
    logic [CH_W-1:0]     ch_d;

    // State register: per-channel envelope state, pending note events,
    // the round-robin pointer and the registered result stream. Only the
    // channel under service has its phase/level rewritten each cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c] <= P_IDLE;
                level_q[c] <= '0;
            end
            pend_on_q   <= '0;
            pend_off_q  <= '0;
            ch          <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_phase_q <= P_IDLE;
            out_level_q <= '0;
            active_q    <= '0;
        end else begin
            phase_q[ch] <= svc_phase;
            level_q[ch] <= svc_level;
            pend_on_q   <= pend_on_d;
            pend_off_q  <= pend_off_d;
            ch          <= ch_d;
            out_valid_q <= 1'b1;
            out_ch_q    <= ch;
            out_phase_q <= svc_phase;
            out_level_q <= svc_level;
            active_q    <= active_d;
        end
    end

    // Next-state logic for the serviced channel. All arithmetic is done one
    // bit wider than the level so that attack overflow and decay/release
    // underflow show up in the top bit. A zero rate freezes the level and
    // the phase, even where the comparison alone would force a transition.
    always_comb begin
        cur_phase = phase_q[ch];
        cur_level = level_q[ch];
        att_sum   = {1'b0, cur_level} + W1'(bus.attack_rate);
        dec_diff  = {1'b0, cur_level} - W1'(bus.decay_rate);
        rel_diff  = {1'b0, cur_level} - W1'(bus.release_rate);
        svc_phase = cur_phase;
        svc_level = cur_level;

        if (pend_on_q[ch]) begin
            svc_phase = P_ATTACK;
            if (!bus.retrig_mode) begin
                svc_level = '0;
            end
        end else if (pend_off_q[ch] && cur_phase != P_IDLE) begin
            svc_phase = P_RELEASE;
        end else begin
            case (cur_phase)
                P_ATTACK: begin
                    if (bus.attack_rate != '0) begin
                        if (att_sum >= {1'b0, MAX}) begin
                            svc_level = MAX;
                            svc_phase = P_DECAY;
                        end else begin
                            svc_level = att_sum[LEVEL_W-1:0];
                        end
                    end
                end
                P_DECAY: begin
                    if (bus.decay_rate != '0) begin
                        if (dec_diff[LEVEL_W] ||
                            dec_diff[LEVEL_W-1:0] <= bus.sustain_level) begin
                            svc_level = bus.sustain_level;
                            svc_phase = P_SUSTAIN;
                        end else begin
                            svc_level = dec_diff[LEVEL_W-1:0];
                        end
                    end
                end
                P_SUSTAIN: begin
                    svc_level = bus.sustain_level;
                end
                P_RELEASE: begin
                    if (bus.release_rate != '0) begin
                        if (rel_diff[LEVEL_W] || rel_diff[LEVEL_W-1:0] == '0) begin
                            svc_level = '0;
                            svc_phase = P_IDLE;
                        end else begin
                            svc_level = rel_diff[LEVEL_W-1:0];
                        end
                    end
                end
                default: begin
                    svc_phase = P_IDLE;
                    svc_level = '0;
                end
            endcase
        end
    end

    // Bookkeeping around the service: event latching, pointer advance and
    // the active vector. The serviced channel's flags are consumed this
    // cycle, so they start from zero and only pick up strobes arriving in
    // this same cycle, which therefore wait for the next service instead of
    // being lost. Note-on is applied last so it wins over a coincident
    // note-off.
    always_comb begin
        pend_on_d  = pend_on_q;
        pend_off_d = pend_off_q;
        active_d   = active_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CH_W'(c) == ch) begin
                pend_on_d[c]  = 1'b0;
                pend_off_d[c] = 1'b0;
            end
            if (bus.gate_off[c]) begin
                pend_off_d[c] = 1'b1;
                pend_on_d[c]  = 1'b0;
            end
            if (bus.gate_on[c]) begin
                pend_on_d[c]  = 1'b1;
                pend_off_d[c] = 1'b0;
            end
        end
        active_d[ch] = (svc_phase != P_IDLE);
        ch_d = (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + CH_W'(1);
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_phase = out_phase_q;
    assign bus.out_level = out_level_q;
    assign bus.active    = active_q;
endmodule

// File: tb/tb_adsr_env_mc.sv
// tb_adsr_env_mc
// Directed bench for adsr_env_mc (4 channels, 16-bit level). A table of
// vectors names the channel whose next service result is checked, the
// strobes/configuration presented in the cycle the vector starts, and the
// hand-computed expected result. Reset behaviour is covered by short
// hand-written sequences around the table.
module tb_adsr_env_mc;
    localparam logic [2:0] IDL = 3'd0;
    localparam logic [2:0] ATK = 3'd1;
    localparam logic [2:0] DEC = 3'd2;
    localparam logic [2:0] SUS = 3'd3;
    localparam logic [2:0] REL = 3'd4;

    typedef struct {
        string       name;
        int          chk_ch;
        logic [3:0]  gon;
        logic [3:0]  goff;
        logic        retrig;
        logic [15:0] att;
        logic [2:0]  exp_phase;
        logic [15:0] exp_level;
        logic [3:0]  exp_active;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   svc_ch;
    vec_t vecs[$];

    adsr_env_mc_if #(.CHANNELS(4), .LEVEL_W(16), .RATE_W(16)) bus ();

    adsr_env_mc #(.CHANNELS(4), .LEVEL_W(16), .RATE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output field against the expected tuple in one go.
    task automatic check_output(input string name, input logic exp_valid,
                                input int exp_ch, input logic [2:0] exp_phase,
                                input logic [15:0] exp_level,
                                input logic [3:0] exp_active);
        n_vec++;
        if (bus.out_valid !== exp_valid || bus.out_ch !== 2'(exp_ch) ||
            bus.out_phase !== exp_phase || bus.out_level !== exp_level ||
            bus.active !== exp_active) begin
            n_err++;
            $display("[TB] FAIL %s: got valid=%0b ch=%0d phase=%0d level=%h active=%b, want valid=%0b ch=%0d phase=%0d level=%h active=%b",
                     name, bus.out_valid, bus.out_ch, bus.out_phase, bus.out_level,
                     bus.active, exp_valid, exp_ch, exp_phase, exp_level, exp_active);
        end
    endtask

    // Present a vector's strobes for one cycle, run until its channel has
    // been serviced and check the registered result.
    task automatic apply_stimulus(input vec_t v);
        int n_edges;
        bus.gate_on     = v.gon;
        bus.gate_off    = v.goff;
        bus.retrig_mode = v.retrig;
        bus.attack_rate = v.att;
        n_edges = ((v.chk_ch - svc_ch + 4) % 4) + 1;
        for (int e = 0; e < n_edges; e++) begin
            step();
            if (e == 0) begin
                bus.gate_on  = '0;
                bus.gate_off = '0;
            end
            svc_ch = (svc_ch + 1) % 4;
        end
        check_output(v.name, 1'b1, v.chk_ch, v.exp_phase, v.exp_level, v.exp_active);
    endtask

    task automatic add(input string n, input int c, input logic [3:0] on,
                       input logic [3:0] off, input logic rt, input logic [15:0] at,
                       input logic [2:0] ph, input logic [15:0] lv, input logic [3:0] ac);
        vec_t v;
        v.name = n; v.chk_ch = c; v.gon = on; v.goff = off; v.retrig = rt;
        v.att = at; v.exp_phase = ph; v.exp_level = lv; v.exp_active = ac;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        svc_ch = 0;

        // Full envelope on ch0, then idle neighbours.
        add("ch1_idle0",     1, 4'h0, 4'h0, 1'b0, 16'h4000, IDL, 16'h0000, 4'b0000);
        add("atk0",          0, 4'h1, 4'h0, 1'b0, 16'h4000, ATK, 16'h0000, 4'b0001);
        add("atk1",          0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'h4000, 4'b0001);
        add("atk2",          0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'h8000, 4'b0001);
        add("atk3",          0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'hC000, 4'b0001);
        add("dec0",          0, 4'h0, 4'h0, 1'b0, 16'h4000, DEC, 16'hFFFF, 4'b0001);
        add("dec1",          0, 4'h0, 4'h0, 1'b0, 16'h4000, DEC, 16'hDFFF, 4'b0001);
        add("dec2",          0, 4'h0, 4'h0, 1'b0, 16'h4000, DEC, 16'hBFFF, 4'b0001);
        add("dec3",          0, 4'h0, 4'h0, 1'b0, 16'h4000, DEC, 16'h9FFF, 4'b0001);
        add("sus0",          0, 4'h0, 4'h0, 1'b0, 16'h4000, SUS, 16'h8000, 4'b0001);
        add("sus1",          0, 4'h0, 4'h0, 1'b0, 16'h4000, SUS, 16'h8000, 4'b0001);
        add("ch2_idle",      2, 4'h0, 4'h0, 1'b0, 16'h4000, IDL, 16'h0000, 4'b0001);
        add("ch3_idle",      3, 4'h0, 4'h0, 1'b0, 16'h4000, IDL, 16'h0000, 4'b0001);
        // Note-off in ch0's own service cycle is deferred one service.
        add("off_deferred",  0, 4'h0, 4'h1, 1'b0, 16'h4000, SUS, 16'h8000, 4'b0001);
        add("rel0",          0, 4'h0, 4'h0, 1'b0, 16'h4000, REL, 16'h8000, 4'b0001);
        add("rel1",          0, 4'h0, 4'h0, 1'b0, 16'h4000, REL, 16'h5000, 4'b0001);
        add("rel2",          0, 4'h0, 4'h0, 1'b0, 16'h4000, REL, 16'h2000, 4'b0001);
        add("rel_idle",      0, 4'h0, 4'h0, 1'b0, 16'h4000, IDL, 16'h0000, 4'b0000);
        // Retrigger at 0xC000, restart then legato.
        add("rt_atk0",       0, 4'h1, 4'h0, 1'b0, 16'h4000, ATK, 16'h0000, 4'b0001);
        add("rt_atk1",       0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'h4000, 4'b0001);
        add("rt_atk2",       0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'h8000, 4'b0001);
        add("rt_atk3",       0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'hC000, 4'b0001);
        add("retrig0",       0, 4'h1, 4'h0, 1'b0, 16'h4000, ATK, 16'h0000, 4'b0001);
        add("lg_atk1",       0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'h4000, 4'b0001);
        add("lg_atk2",       0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'h8000, 4'b0001);
        add("lg_atk3",       0, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'hC000, 4'b0001);
        add("legato",        0, 4'h1, 4'h0, 1'b1, 16'h4000, ATK, 16'hC000, 4'b0001);
        add("legato_dec",    0, 4'h0, 4'h0, 1'b1, 16'h4000, DEC, 16'hFFFF, 4'b0001);
        // Colliding / discarded events.
        add("on_off_same",   2, 4'h4, 4'h4, 1'b0, 16'h4000, ATK, 16'h0000, 4'b0101);
        add("off_in_idle",   1, 4'h0, 4'h2, 1'b0, 16'h4000, IDL, 16'h0000, 4'b0101);
        add("off_discard",   1, 4'h0, 4'h0, 1'b0, 16'h4000, IDL, 16'h0000, 4'b0101);
        // Zero attack rate holds, then a full-scale rate jumps to decay.
        add("zr_start",      0, 4'h1, 4'h0, 1'b0, 16'h0000, ATK, 16'h0000, 4'b0101);
        add("zr_hold1",      0, 4'h0, 4'h0, 1'b0, 16'h0000, ATK, 16'h0000, 4'b0101);
        add("zr_hold2",      0, 4'h0, 4'h0, 1'b0, 16'h0000, ATK, 16'h0000, 4'b0101);
        add("zr_full",       0, 4'h0, 4'h0, 1'b0, 16'hFFFF, DEC, 16'hFFFF, 4'b0101);
        add("ch2_dec",       2, 4'h0, 4'h0, 1'b0, 16'h4000, DEC, 16'hDFFF, 4'b0101);
        // Note-on in ch3's own service cycle lands one service later.
        add("on3_deferred",  3, 4'h8, 4'h0, 1'b0, 16'h4000, IDL, 16'h0000, 4'b0101);
        add("on3_taken",     3, 4'h0, 4'h0, 1'b0, 16'h4000, ATK, 16'h0000, 4'b1101);

        rst               = 1'b0;
        bus.gate_on       = '0;
        bus.gate_off      = '0;
        bus.attack_rate   = 16'h4000;
        bus.decay_rate    = 16'h2000;
        bus.sustain_level = 16'h8000;
        bus.release_rate  = 16'h3000;
        bus.retrig_mode   = 1'b0;

        step();
        step();
        check_output("reset_state", 1'b0, 0, IDL, 16'h0000, 4'b0000);
        rst = 1'b1;
        #1;
        check_output("first_after_release", 1'b0, 0, IDL, 16'h0000, 4'b0000);
        svc_ch = 0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
        end

        // Reset for one cycle while ch0/ch2 are decaying; strobes presented
        // on the reset edge must be dropped.
        rst = 1'b0;
        bus.gate_on = 4'hF;
        step();
        check_output("mid_reset", 1'b0, 0, IDL, 16'h0000, 4'b0000);
        rst = 1'b1;
        bus.gate_on = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            check_output($sformatf("post_reset_ch%0d", c), 1'b1, c, IDL, 16'h0000, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adsr_env_mc.md
# adsr_env_mc

Time-multiplexed, parametrised multi-channel ADSR envelope generator for the voice section. It is the successor to the single-voice ADSR phase sequencer and owns the level arithmetic itself instead of driving an external NCO. `CHANNELS` independent envelopes share one update datapath, servicing one channel per clock in round-robin order. Each envelope supports rate-based attack/decay/release, a programmable sustain level and a selectable retrigger mode. Output is a registered per-service stream of (channel, phase, level) that feeds the VCA/mixer.

## Interface
- `CHANNELS`, 4: number of envelopes; ≥2, power of two not required.
- `LEVEL_W`, 16: envelope level width; full scale MAX = 2^LEVEL_W−1.
- `RATE_W`, 16: rate input width; must satisfy RATE_W ≤ LEVEL_W.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-low (`rst`==0 resets on the clk edge).
- `gate_on`  in  CHANNELS  per-channel note-on strobe, any cycle.
- `gate_off`  in  CHANNELS  per-channel note-off strobe, any cycle.
- `attack_rate`  in  RATE_W  level increment per attack step, shared by all channels.
- `decay_rate`  in  RATE_W  level decrement per decay step.
- `sustain_level`  in  LEVEL_W  sustain target.
- `release_rate`  in  RATE_W  level decrement per release step.
- `retrig_mode`  in  1  0: note-on restarts from level 0; 1: legato, attack resumes from current level.
- `out_valid`  out  1  out_* carry a fresh service result.
- `out_ch`  out  $clog2(CHANNELS)  channel just serviced.
- `out_phase`  out  3  phase of that channel: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `out_level`  out  LEVEL_W  level of that channel.
- `active`  out  CHANNELS  bit c = channel c phase ≠ IDLE, updated at its service.

## Operation
- Per-channel state: phase (3 b), level (LEVEL_W), pend_on, pend_off.
- Channel pointer `ch` counts 0..CHANNELS−1 and wraps to 0. One channel is serviced per cycle.
- Event latching, every cycle, for every channel:
  - A `gate_on` bit sets pend_on=1 and clears pend_off.
  - A `gate_off` bit sets pend_off=1 and clears pend_on.
  - Both in the same cycle: on wins.
- Clearing at service: pending flags of the serviced channel are cleared. An event arriving in the service cycle of its own channel is latched for the next service and is never lost.
- Service of channel c, in priority order:
  1. pend_on: phase←ATTACK. Level←0 if retrig_mode=0, otherwise unchanged. No level step this service.
  2. pend_off and phase≠IDLE: phase←RELEASE, level unchanged. A pend_off in IDLE is discarded.
  3. Otherwise, by phase:
     - ATTACK: level+attack_rate, computed in LEVEL_W+1 bits. If the sum ≥ MAX, level←MAX and phase←DECAY.
     - DECAY: if level−decay_rate ≤ sustain_level, or the subtraction underflows, level←sustain_level and phase←SUSTAIN. Otherwise subtract.
     - SUSTAIN: level←sustain_level, so it tracks live changes.
     - RELEASE: if level−release_rate ≤ 0 or underflows, level←0 and phase←IDLE. Otherwise subtract.
     - IDLE: level←0.
- Rates are zero-extended. A rate of 0 holds the level and stays in phase (no forced transition).
- sustain_level=MAX: decay terminates on its first step, at MAX.

## Timing
- Reset values: ch=0; every phase=IDLE; every level=0; pending flags cleared; out_valid=0; out_ch=0; out_phase=0; out_level=0; active=0.
- The service decision uses pending state as of the start of the cycle plus same-cycle strobes per the latching rules above. Exception: a strobe for the channel being serviced in that same cycle is deferred.
- Latency: channel c serviced in cycle t → out_ch=c with its updated phase/level registered at t+1; active[c] is updated at t+1.
- out_valid: 0 in the first cycle after reset release, then 1 continuously.
- Each channel is stepped once every CHANNELS cycles.
- Reset asserted mid-envelope: on that edge all state returns to reset values; strobes in that cycle are dropped.

## Test plan
Configuration: CHANNELS=4, LEVEL_W=16, attack 0x4000, decay 0x2000, sustain 0x8000, release 0x3000.
- Full envelope, ch0: `gate_on[0]` pulse.
  - Successive ch0 outputs: ATTACK 0x0000, 0x4000, 0x8000, 0xC000.
  - Then DECAY 0xFFFF, 0xDFFF, 0xBFFF, 0x9FFF.
  - Then SUSTAIN 0x8000, repeated.
  - Channels 1–3 stay IDLE/0.
- Release from sustain: `gate_off[0]` → ch0 shows RELEASE 0x8000, then 0x5000, 0x2000, then IDLE 0x0000; active[0] falls on the same output.
- Retrigger: `gate_on[0]` at level 0xC000.
  - retrig_mode=0 → next ch0 output ATTACK 0x0000.
  - retrig_mode=1 → ATTACK 0xC000, then 0xFFFF DECAY.
- Simultaneous/colliding events:
  - `gate_on[2]` and `gate_off[2]` in the same cycle → ATTACK.
  - `gate_off[1]` while ch1 is IDLE → stays IDLE.
  - `gate_on[3]` in ch3's own service cycle → takes effect at ch3's next service, 4 cycles later.
- Zero rate: attack_rate=0 → ch0 holds ATTACK 0x0000 indefinitely. Setting attack_rate=0xFFFF → next ch0 step gives 0xFFFF DECAY.
- Reset mid-operation: drive `rst`=0 one cycle during DECAY → next cycle all outputs 0, out_valid=0, then round-robin restarts at out_ch=0 with every channel IDLE.
